// File: rtl/uart_tx_fifo_if.sv
// Handshake bundle between the APB register block, the TX FIFO and the UART transmitter core.
// Optional overflow flag signals are present when UART_TX_FIFO_OVF_FLAG_EN is defined.
interface uart_tx_fifo_if #(
  parameter int ADDR_W = 4
);
  logic              wr_en;
  logic [7:0]        wr_data;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              tx_busy;
  logic              tx_start;
  logic [7:0]        tx_data;
`ifdef UART_TX_FIFO_OVF_FLAG_EN
  logic              ovf_clr;
  logic              ovf;

  modport master (
    output wr_en, wr_data, tx_busy, ovf_clr,
    input  full, empty, count, tx_start, tx_data, ovf
  );

  modport slave (
    input  wr_en, wr_data, tx_busy, ovf_clr,
    output full, empty, count, tx_start, tx_data, ovf
  );
`else
  modport master (
    output wr_en, wr_data, tx_busy,
    input  full, empty, count, tx_start, tx_data
  );

  modport slave (
    input  wr_en, wr_data, tx_busy,
    output full, empty, count, tx_start, tx_data
  );
`endif
endinterface

// File: rtl/uart_tx_fifo.sv
// Circular byte FIFO feeding the UART transmitter with a one-cycle launch pulse per byte.
// Optional sticky overflow flag: define UART_TX_FIFO_OVF_FLAG_EN.
module uart_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input logic           clk,
  input logic           rst,
  uart_tx_fifo_if.slave bus
);

  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  generate
    if ((DEPTH < 2) || ((1 << ADDR_W) != DEPTH)) begin : g_bad_cfg
      $error("uart_tx_fifo: DEPTH must be a power of two >= 2 and equal 2**ADDR_W");
    end
  endgenerate

  state_t            state;
  state_t            state_nxt;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_q;
  logic              full_w;
  logic              empty_w;
  logic              push;
  logic              pop;
  logic              tx_start_nxt;
  logic              tx_start_q;
  logic [7:0]        tx_data_q;

  // Status comes from the registered count, so a same-cycle pop never frees a slot for a write.
  assign full_w  = (count_q == FULL_LVL);
  assign empty_w = (count_q == '0);
  assign push    = bus.wr_en && !full_w;

  assign bus.full     = full_w;
  assign bus.empty    = empty_w;
  assign bus.count    = count_q;
  assign bus.tx_start = tx_start_q;
  assign bus.tx_data  = tx_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (!empty_w && !bus.tx_busy) state_nxt = LAUNCH;
      LAUNCH:    state_nxt = WAIT_BUSY;
      WAIT_BUSY: if (bus.tx_busy) state_nxt = WAIT_DONE;
      WAIT_DONE: if (!bus.tx_busy) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // The pop edge loads tx_data and raises tx_start together, so both are valid in LAUNCH.
  always_comb begin
    pop          = 1'b0;
    tx_start_nxt = 1'b0;
    if ((state == IDLE) && !empty_w && !bus.tx_busy) begin
      pop          = 1'b1;
      tx_start_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      tx_start_q <= tx_start_nxt;
      if (push) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + ADDR_W'(1);
        tx_data_q <= mem[rd_ptr];
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + (ADDR_W+1)'(1);
        2'b01:   count_q <= count_q - (ADDR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef UART_TX_FIFO_OVF_FLAG_EN
  logic ovf_q;

  assign bus.ovf = ovf_q;

  // Set has priority over a coincident clear so no overflow event is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (bus.wr_en && full_w) begin
      ovf_q <= 1'b1;
    end else if (bus.ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end
`endif

endmodule
